time_entry: RTL and testbench

- Input-side counterpart of the time display path. It turns the raw board buttons and switches into a validated time-load command for the clock module.
- It debounces two active-low push buttons and steps through hour, minute and second edit fields.
- The edited field's value comes from sw[5:0]. The result is issued as a one-cycle load strobe with hour/min/sec.
- It also drives a clock-run enable and a per-field blink mask to the 7-segment controller.

---
 rtl/clock_pkg.sv | 32 +++
 rtl/time_entry_debounce.sv | 52 +++++
 rtl/time_entry.sv | 177 +++++++++++++++++
 tb/tb_time_entry.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared edit states, field widths and limits for time entry.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        EDIT_H = 3'd1,
        EDIT_M = 3'd2,
        EDIT_S = 3'd3,
        COMMIT = 3'd4
    } edit_state_e;

    function automatic logic [5:0] clamp(input logic [5:0] value, input logic [5:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_entry_debounce.sv
// ============================================================================
// Module      : debounce
// Description : 2-flop synchroniser, stability counter and press pulse for an
//               active-low button.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Flip only after CYCLES consecutive differing samples.
                level <= sync_2;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_entry.sv
// ============================================================================
// Module      : time_entry
// Description : Button/switch time editor producing a clamped load command,
//               clock run enable and per-field blink mask.
//               Optional edit timeout: define TIME_ENTRY_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_entry
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_mode_n,
    input  logic              btn_set_n,
    input  logic [5:0]        sw,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [SEC_W-1:0]  load_sec,
    output logic              run_en,
    output logic              editing,
    output logic [2:0]        blink_mask
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("time_entry: cycle parameters must be at least 2");
    end

    logic mode_ev;
    logic set_ev;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_mode_n),
        .press   (mode_ev)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_set_n),
        .press   (set_ev)
    );

    edit_state_e       state;
    edit_state_e       state_nx;
    logic [HOUR_W-1:0] sh_hour;
    logic [MIN_W-1:0]  sh_min;
    logic [SEC_W-1:0]  sh_sec;
    logic [BW-1:0]     blink_cnt;
    logic [BW-1:0]     blink_cnt_nx;
    logic              phase;
    logic              phase_nx;
    logic              in_edit;
    logic              timed_out;
    logic [5:0]        hour_clamped;

    assign in_edit      = (state == EDIT_H) || (state == EDIT_M) || (state == EDIT_S);
    assign hour_clamped = clamp(sw, MAX_HOUR);

`ifdef TIME_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (!in_edit || mode_ev || set_ev || timed_out) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timed_out = in_edit && !mode_ev && !set_ev && (idle_cnt == TIMEOUT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        blink_cnt_nx = blink_cnt;
        phase_nx     = phase;
        case (state)
            RUN:     if (mode_ev) state_nx = EDIT_H;
            EDIT_H:  if (mode_ev) state_nx = EDIT_M;
            EDIT_M:  if (mode_ev) state_nx = EDIT_S;
            EDIT_S:  if (mode_ev) state_nx = COMMIT;
            COMMIT:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
        if (timed_out) begin
            state_nx = RUN;
        end

        if (state == RUN && state_nx == EDIT_H) begin
            blink_cnt_nx = '0;
            phase_nx     = 1'b0;
        end else if (in_edit) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                phase_nx     = ~phase;
            end else begin
                blink_cnt_nx = blink_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            sh_hour    <= '0;
            sh_min     <= '0;
            sh_sec     <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            load       <= 1'b0;
            load_hour  <= '0;
            load_min   <= '0;
            load_sec   <= '0;
            run_en     <= 1'b1;
            editing    <= 1'b0;
            blink_mask <= 3'b000;
        end else begin
            state     <= state_nx;
            blink_cnt <= blink_cnt_nx;
            phase     <= phase_nx;

            if (state == RUN && mode_ev) begin
                sh_hour <= cur_hour;
                sh_min  <= cur_min;
                sh_sec  <= cur_sec;
            end else if (set_ev && !mode_ev) begin
                case (state)
                    EDIT_H:  sh_hour <= hour_clamped[HOUR_W-1:0];
                    EDIT_M:  sh_min  <= clamp(sw, MAX_MIN);
                    EDIT_S:  sh_sec  <= clamp(sw, MAX_SEC);
                    default: ;
                endcase
            end

            load <= (state_nx == COMMIT);
            if (state_nx == COMMIT) begin
                load_hour <= sh_hour;
                load_min  <= sh_min;
                load_sec  <= sh_sec;
            end

            run_en  <= (state_nx == RUN);
            editing <= (state_nx == EDIT_H) || (state_nx == EDIT_M) || (state_nx == EDIT_S);
            case (state_nx)
                EDIT_H:  blink_mask <= {phase_nx, 2'b00};
                EDIT_M:  blink_mask <= {1'b0, phase_nx, 1'b0};
                EDIT_S:  blink_mask <= {2'b00, phase_nx};
                default: blink_mask <= 3'b000;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_entry.sv
// ============================================================================
// Module      : tb_time_entry
// Description : Directed self-checking bench for time_entry (short cycle params).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_entry;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode_n;
    logic       btn_set_n;
    logic [5:0] sw;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       run_en;
    logic       editing;
    logic [2:0] blink_mask;

    int checks = 0;
    int errors = 0;

    int         load_cnt = 0;
    logic [4:0] cap_hour;
    logic [5:0] cap_min;
    logic [5:0] cap_sec;
    logic       cap_run;
    logic       cap_edit;
    logic       after_pending = 1'b0;
    logic       after_run;

    time_entry #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_mode_n (btn_mode_n),
        .btn_set_n  (btn_set_n),
        .sw         (sw),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .load       (load),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .run_en     (run_en),
        .editing    (editing),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (load) begin
                load_cnt      <= load_cnt + 1;
                cap_hour      <= load_hour;
                cap_min       <= load_min;
                cap_sec       <= load_sec;
                cap_run       <= run_en;
                cap_edit      <= editing;
                after_pending <= 1'b1;
            end else if (after_pending) begin
                after_run     <= run_en;
                after_pending <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input bit mode, input bit set);
        @(negedge clk);
        btn_mode_n = !mode;
        btn_set_n  = !set;
        repeat (10) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_set_n  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [2:0] v;
        bit         seen;

        reset_n    = 1'b0;
        btn_mode_n = 1'b1;
        btn_set_n  = 1'b1;
        sw         = 6'd0;
        cur_hour   = 5'd10;
        cur_min    = 6'd20;
        cur_sec    = 6'd30;
        repeat (3) @(negedge clk);
        check("rst_load", load, 0);
        check("rst_run_en", run_en, 1);
        check("rst_editing", editing, 0);
        check("rst_blink", blink_mask, 0);
        check("rst_load_vals", {load_hour, load_min, load_sec}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Debounce: short glitch ignored, long press gives one event
        btn_mode_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_editing", editing, 0);
        check("glitch_run_en", run_en, 1);

        btn_mode_n = 1'b0;
        repeat (6) @(negedge clk);
        check("press_before_edit", editing, 0);
        @(negedge clk);
        check("press_edit", editing, 1);
        check("press_run_en", run_en, 0);
        repeat (3) @(negedge clk);
        btn_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check("release_still_edit", editing, 1);

        // 2. Full edit with set on the hour field
        sw = 6'd7;
        press(0, 1);
        press(1, 0);
        press(1, 0);
        check("pre_commit_loads", load_cnt, 0);
        press(1, 0);
        check("edit_load_cnt", load_cnt, 1);
        check("edit_load_hour", cap_hour, 7);
        check("edit_load_min", cap_min, 20);
        check("edit_load_sec", cap_sec, 30);
        check("commit_run_en", cap_run, 0);
        check("commit_editing", cap_edit, 0);
        check("after_commit_run_en", after_run, 1);
        check("load_hold", {load_hour, load_min, load_sec}, {5'd7, 6'd20, 6'd30});
        check("idle_load_low", load, 0);

        // 3. Clamping on every field
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        press(1, 0);
        sw = 6'd40; press(0, 1); press(1, 0);
        sw = 6'd63; press(0, 1); press(1, 0);
        sw = 6'd60; press(0, 1); press(1, 0);
        check("clamp_load_cnt", load_cnt, 2);
        check("clamp_hour", cap_hour, 23);
        check("clamp_min", cap_min, 59);
        check("clamp_sec", cap_sec, 59);

        // 4. Simultaneous mode+set in EDIT_H, then blink in EDIT_M
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        sw = 6'd12;
        press(1, 0);
        press(1, 1);
        check("simul_editing", editing, 1);
        seen = 1'b0;
        v = blink_mask;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (blink_mask !== v) seen = 1'b1;
        end
        check("blink_toggle_seen", seen, 1);
        v = blink_mask;
        check("blink_field_m", v & 3'b101, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("blink_hold", blink_mask, v);
        end
        @(negedge clk);
        check("blink_flip", blink_mask, (v == 3'b000) ? 3'b010 : 3'b000);
        press(1, 0);
        press(1, 0);
        check("simul_load_cnt", load_cnt, 3);
        check("simul_hour_kept", cap_hour, 5);
        check("simul_min", cap_min, 6);
        check("simul_sec", cap_sec, 7);

        // 5. Asynchronous reset while in EDIT_S
        cur_hour = 5'd9; cur_min = 6'd9; cur_sec = 6'd9;
        press(1, 0); press(1, 0); press(1, 0);
        check("rst_mid_pre_edit", editing, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_run_en", run_en, 1);
        check("rst_mid_editing", editing, 0);
        check("rst_mid_blink", blink_mask, 0);
        check("rst_mid_load_vals", {load_hour, load_min, load_sec}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_no_load", load_cnt, 3);
        check("rst_mid_after_run", run_en, 1);

        // 6. Idle behaviour in an edit
        cur_hour = 5'd4; cur_min = 6'd5; cur_sec = 6'd6;
        press(1, 0);
        repeat (80) @(negedge clk);
`ifdef TIME_ENTRY_TIMEOUT_EN
        check("timeout_editing", editing, 0);
        check("timeout_run_en", run_en, 1);
        check("timeout_no_load", load_cnt, 3);
`else
        check("persist_editing", editing, 1);
        press(1, 0); press(1, 0); press(1, 0);
        check("persist_load_cnt", load_cnt, 4);
        check("persist_load", {cap_hour, cap_min, cap_sec}, {5'd4, 6'd5, 6'd6});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
